rmii_send_frame_50_mhz: RTL and testbench
=========================================

# rmii_send_frame_50_MHz

RMII frame transmitter for the Ethernet MAC datapath, clocked from the 50 MHz RMII reference clock. It accepts payload bytes through a byte-level pull handshake and generates the preamble and SFD. It appends the IEEE 802.3 FCS, enforces the inter-frame gap, and drives TXD[1:0]/TX_EN to the PHY at 100 Mbit/s or 10 Mbit/s.

## Interface
- No parameters.
- clk  in  1  50 MHz RMII reference clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- fast_eth  in  1  1 = 100 Mbit/s, 0 = 10 Mbit/s; latched at frame start only
- tx_data  in  8  payload byte presented by source
- tx_valid  in  1  tx_data valid; in IDLE also requests frame start
- tx_last  in  1  qualifies tx_data as final payload byte
- tx_ack  out  1  one-clock pulse: current tx_data captured, present next byte
- busy  out  1  frame in progress (preamble through end of IFG)
- err  out  1  one-clock pulse on payload underrun
- rm_tx_data  out  2  RMII TXD[1:0], registered
- rm_tx_en  out  1  RMII TX_EN, registered

## Operation
- Dibit tick: every clk when the latched speed is 1; every 10th clk when it is 0, using a 0..9 counter. Each dibit is held 10 clocks. All shifting, counting and state changes occur on ticks only.
- Bytes are sent LSB dibit first: bits [1:0], [3:2], [5:4], [7:6].
- IDLE: rm_tx_en=0, rm_tx_data=00, busy=0. On tx_valid=1, latch fast_eth, set busy=1, reset the tick counter, and enter PRE.
- PRE: 7 bytes of 0x55 (28 dibits of 01).
- SFD: 0xD5 (dibits 01,01,01,11).
- DATA: at each byte boundary, entering from SFD or after a byte's 4th dibit:
  - If tx_valid=1: capture tx_data and tx_last, pulse tx_ack, and drive the first dibit on the same edge.
  - Captured byte with tx_last=1: after its 4th dibit, go to FCS.
  - tx_valid=0 at a boundary: underrun. rm_tx_en drops on that edge, err pulses, no FCS is sent, and the block enters IFG.
- FCS: CRC-32, reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, updated over payload bytes only. The transmitted value is ~crc, low byte first, LSB dibit first (16 dibits).
- IFG: rm_tx_en=0, rm_tx_data=00 for 48 ticks (96 bit times), then IDLE with busy=0. A tx_valid already high starts the next frame on the following IDLE edge.
- CRC register reset to 0xFFFFFFFF on every frame start.
- No padding or length check; the source supplies ≥1 byte. tx_last is ignored when tx_valid=0.
- fast_eth changes while busy=1 have no effect until the next frame.
- Reset (any time, including mid-frame): all outputs 0, state IDLE, tick counter 0, CRC 0xFFFFFFFF. Release resumes in IDLE.

## Timing
- Reset values: rm_tx_en=0, rm_tx_data=00, tx_ack=0, busy=0, err=0.
- Start latency: the edge that samples tx_valid=1 in IDLE drives rm_tx_en=1, rm_tx_data=01, busy=1.
- 100 Mbit/s, start edge = E0:
  - Preamble+SFD occupy E0..E31.
  - First payload dibit and first tx_ack at E32.
  - Subsequent tx_ack every 4 clocks. The source has 3 clocks after each tx_ack to update tx_data/tx_last/tx_valid.
- 10 Mbit/s: all tick-based intervals ×10. The first tx_ack is at E320; the source has 39 clocks to update.
- Frame with N payload bytes: rm_tx_en high for (32+4N+16) ticks. busy falls 48 ticks after rm_tx_en falls.
- tx_ack and err are never asserted together. Neither is asserted outside DATA.

## Test plan
- 100 Mbit/s, payload ASCII "123456789", tx_last on '9' -> 28×01 dibits, then 01,01,01,11, then 0x31 as 01,00,11,00 ... FCS bytes 26 39 F4 CB. rm_tx_en high exactly 84 clocks; 9 tx_ack pulses 4 clocks apart starting E32; busy low 48 clocks after rm_tx_en falls.
- Same frame at 10 Mbit/s -> identical dibit sequence, each dibit held 10 clocks. rm_tx_en high 840 clocks; IFG 480 clocks.
- Underrun: 100 Mbit/s, drop tx_valid after 3rd byte -> rm_tx_en falls at the 4th byte boundary (E44), err one pulse, no FCS dibits, busy falls 48 clocks later.
- Back-to-back: hold tx_valid=1 after tx_last -> second frame's rm_tx_en rises exactly one clock after busy falls. fast_eth toggled mid-frame does not alter the first frame's dibit timing.
- Reset asserted mid-DATA at 10 Mbit/s -> outputs 0 immediately (asynchronous). After release with tx_valid=1, a full clean frame with correct FCS follows.
- Single-byte payload 0x00 with tx_last -> FCS bytes 8D EF 02 D2. rm_tx_en high 52 clocks at 100 Mbit/s.

Source files
------------

// File: rtl/rmii_send_frame_50_mhz.sv
// rtl/rmii_send_frame_50_mhz.sv - RMII frame transmitter with preamble/SFD, FCS and IFG generation
//
// Ports:
//   clk         50 MHz RMII reference clock
//   rst         asynchronous active-low reset
//   fast_eth    1 = 100 Mbit/s, 0 = 10 Mbit/s, sampled at frame start
//   tx_data     payload byte from the source
//   tx_valid    payload byte valid; in idle it also requests a new frame
//   tx_last     marks tx_data as the final payload byte
//   tx_ack      one-clock pulse when tx_data has been captured
//   busy        frame in progress, preamble through end of inter-frame gap
//   err         one-clock pulse on payload underrun
//   rm_tx_data  RMII TXD[1:0]
//   rm_tx_en    RMII TX_EN

module rmii_send_frame_50_mhz (
    input  logic       clk,
    input  logic       rst,
    input  logic       fast_eth,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ack,
    output logic       busy,
    output logic       err,
    output logic [1:0] rm_tx_data,
    output logic       rm_tx_en
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_SFD  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_FCS  = 3'd4;
    localparam logic [2:0] ST_IFG  = 3'd5;

    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

    logic [2:0]  state_q, state_d;
    logic        speed_q, speed_d;
    logic [3:0]  div_q,   div_d;
    logic [5:0]  idx_q,   idx_d;
    logic [7:0]  byte_q,  byte_d;
    logic        last_q,  last_d;
    logic [31:0] crc_q,   crc_d;
    logic        busy_q,  busy_d;
    logic        ack_q,   ack_d;
    logic        err_q,   err_d;
    logic [1:0]  txd_q,   txd_d;
    logic        txen_q,  txen_d;

    logic        tick;
    logic        boundary;
    logic [31:0] crc_upd;
    logic [31:0] fcs;
    logic [3:0]  fcs_nidx;

    // Reflected CRC-32 update over one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // At 10 Mbit/s the divider wraps 0..9 and only the wrap clock is a tick.
    assign tick     = speed_q | (div_q == 4'd9);
    assign crc_upd  = crc32_byte(crc_q, tx_data);
    assign fcs      = ~crc_q;
    assign fcs_nidx = idx_q[3:0] + 4'd1;

    // A byte boundary is reached after the last SFD dibit, or after the 4th
    // dibit of a payload byte that was not flagged as last.
    assign boundary = tick && (idx_q == 6'd3) &&
                      ((state_q == ST_SFD) || ((state_q == ST_DATA) && !last_q));

    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        last_d  = last_q;
        crc_d   = crc_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        txd_d   = txd_q;
        txen_d  = txen_q;

        if (state_q == ST_IDLE || speed_q || div_q == 4'd9) begin
            div_d = 4'd0;
        end else begin
            div_d = div_q + 4'd1;
        end

        case (state_q)
            ST_IDLE: begin
                txen_d = 1'b0;
                txd_d  = 2'b00;
                busy_d = 1'b0;
                if (tx_valid) begin
                    // First preamble dibit goes out on the start edge itself.
                    speed_d = fast_eth;
                    busy_d  = 1'b1;
                    div_d   = 4'd0;
                    idx_d   = 6'd0;
                    last_d  = 1'b0;
                    crc_d   = CRC_INIT;
                    state_d = ST_PRE;
                    txen_d  = 1'b1;
                    txd_d   = 2'b01;
                end
            end

            ST_PRE: begin
                if (tick) begin
                    txd_d = 2'b01;
                    if (idx_q == 6'd27) begin
                        state_d = ST_SFD;
                        idx_d   = 6'd0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end

            ST_SFD: begin
                if (tick && idx_q != 6'd3) begin
                    idx_d = idx_q + 6'd1;
                    txd_d = (idx_q == 6'd2) ? 2'b11 : 2'b01;
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (idx_q != 6'd3) begin
                        idx_d = idx_q + 6'd1;
                        case (idx_q[1:0])
                            2'd0:    txd_d = byte_q[3:2];
                            2'd1:    txd_d = byte_q[5:4];
                            default: txd_d = byte_q[7:6];
                        endcase
                    end else if (last_q) begin
                        state_d = ST_FCS;
                        idx_d   = 6'd0;
                        txd_d   = fcs[1:0];
                    end
                end
            end

            ST_FCS: begin
                if (tick) begin
                    if (idx_q == 6'd15) begin
                        state_d = ST_IFG;
                        idx_d   = 6'd0;
                        txen_d  = 1'b0;
                        txd_d   = 2'b00;
                    end else begin
                        idx_d = idx_q + 6'd1;
                        txd_d = fcs[{fcs_nidx, 1'b0} +: 2];
                    end
                end
            end

            ST_IFG: begin
                txen_d = 1'b0;
                txd_d  = 2'b00;
                if (tick) begin
                    if (idx_q == 6'd47) begin
                        state_d = ST_IDLE;
                        idx_d   = 6'd0;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = 6'd0;
                busy_d  = 1'b0;
                txen_d  = 1'b0;
                txd_d   = 2'b00;
            end
        endcase

        // Byte boundary: either pull the next payload byte or abort on underrun.
        if (boundary) begin
            if (tx_valid) begin
                byte_d  = tx_data;
                last_d  = tx_last;
                crc_d   = crc_upd;
                ack_d   = 1'b1;
                state_d = ST_DATA;
                idx_d   = 6'd0;
                txen_d  = 1'b1;
                txd_d   = tx_data[1:0];
            end else begin
                err_d   = 1'b1;
                state_d = ST_IFG;
                idx_d   = 6'd0;
                txen_d  = 1'b0;
                txd_d   = 2'b00;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            speed_q <= 1'b0;
            div_q   <= 4'd0;
            idx_q   <= 6'd0;
            byte_q  <= 8'd0;
            last_q  <= 1'b0;
            crc_q   <= CRC_INIT;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            txd_q   <= 2'b00;
            txen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            crc_q   <= crc_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            txd_q   <= txd_d;
            txen_q  <= txen_d;
        end
    end

    assign tx_ack     = ack_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign rm_tx_data = txd_q;
    assign rm_tx_en   = txen_q;

endmodule

// File: tb/tb_rmii_send_frame_50_mhz.sv
// tb/tb_rmii_send_frame_50_mhz.sv - scoreboard bench for rmii_send_frame_50_mhz

module tb_rmii_send_frame_50_mhz;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic       fast_eth;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ack;
    logic       busy;
    logic       err;
    logic [1:0] rm_tx_data;
    logic       rm_tx_en;

    int vectors     = 0;
    int miscompares = 0;

    // Expected per-clock output word: {en, txd[1:0], ack, err, busy}
    logic [5:0] exp_q[$];

    bq_t p9;
    bq_t p0;

    always #10 clk = ~clk;

    rmii_send_frame_50_mhz dut (
        .clk        (clk),
        .rst        (rst),
        .fast_eth   (fast_eth),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_ack     (tx_ack),
        .busy       (busy),
        .err        (err),
        .rm_tx_data (rm_tx_data),
        .rm_tx_en   (rm_tx_en)
    );

    // Monitor: one expected word per clock while the scoreboard holds entries;
    // any DUT activity with an empty scoreboard is an error.
    initial begin
        logic [5:0] act;
        logic [5:0] e;
        forever begin
            @(negedge clk);
            act = {rm_tx_en, rm_tx_data, tx_ack, err, busy};
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL trace @%0t: en/txd/ack/err/busy got %b want %b", $time, act, e);
                end
            end else if (act !== 6'd0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_activity @%0t: got %b want 000000", $time, act);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_rep(input logic en, input logic [1:0] d, input logic first_ack,
                            input logic first_err, input logic b, input int n);
        for (int r = 0; r < n; r++) begin
            exp_q.push_back({en, d, first_ack && (r == 0), first_err && (r == 0), b});
        end
    endtask

    // n_underrun < 0: complete frame; otherwise the source stops after that many bytes.
    task automatic push_frame(input bq_t pl, input logic [31:0] fcs, input bit fast,
                              input int n_underrun);
        int         reps;
        int         nb;
        logic [7:0] b;
        reps = fast ? 1 : 10;
        for (int i = 0; i < 28; i++) push_rep(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, reps);
        push_rep(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, reps);
        push_rep(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, reps);
        push_rep(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, reps);
        push_rep(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, reps);
        nb = (n_underrun < 0) ? pl.size() : n_underrun;
        for (int i = 0; i < nb; i++) begin
            b = pl[i];
            push_rep(1'b1, b[1:0], 1'b1, 1'b0, 1'b1, reps);
            push_rep(1'b1, b[3:2], 1'b0, 1'b0, 1'b1, reps);
            push_rep(1'b1, b[5:4], 1'b0, 1'b0, 1'b1, reps);
            push_rep(1'b1, b[7:6], 1'b0, 1'b0, 1'b1, reps);
        end
        if (n_underrun >= 0) begin
            push_rep(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, reps);
            push_rep(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 47 * reps);
        end else begin
            for (int k = 0; k < 16; k++) push_rep(1'b1, fcs[2*k +: 2], 1'b0, 1'b0, 1'b1, reps);
            push_rep(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 48 * reps);
        end
    endtask

    task automatic wait_ack();
        bit got;
        got = 1'b0;
        for (int n = 0; n < 1000 && !got; n++) begin
            @(negedge clk);
            if (tx_ack === 1'b1) got = 1'b1;
        end
        #1;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL ack_timeout @%0t: got no tx_ack, want tx_ack within 1000 clocks", $time);
        end
    endtask

    task automatic source(input bq_t pl, input int stop_at, input bit hold_valid, input int toggle_at);
        for (int i = 0; i < pl.size(); i++) begin
            tx_data  = pl[i];
            tx_last  = (i == pl.size() - 1);
            tx_valid = 1'b1;
            wait_ack();
            if (i + 1 == toggle_at) fast_eth = ~fast_eth;
            if (i + 1 == stop_at) begin
                tx_valid = hold_valid;
                tx_last  = 1'b0;
                return;
            end
        end
        tx_valid = hold_valid;
        tx_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 3000 && exp_q.size() != 0; n++) @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_%s: %0d expected words left, want 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic check_quiet(input string name);
        vectors++;
        if ({rm_tx_en, rm_tx_data, tx_ack, err, busy} !== 6'd0) begin
            miscompares++;
            $display("FAIL %s: en/txd/ack/err/busy got %b want 000000", name,
                     {rm_tx_en, rm_tx_data, tx_ack, err, busy});
        end
    endtask

    initial begin
        p9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        p0 = '{8'h00};
        rst      = 1'b0;
        fast_eth = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_quiet("reset_state");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;

        // 100 Mbit/s "123456789"
        fast_eth = 1'b1;
        push_frame(p9, 32'hCBF4_3926, 1'b1, -1);
        source(p9, -1, 1'b0, -1);
        drain("fast_9");

        // 10 Mbit/s "123456789"
        fast_eth = 1'b0;
        push_frame(p9, 32'hCBF4_3926, 1'b0, -1);
        source(p9, -1, 1'b0, -1);
        drain("slow_9");

        // Underrun after 3 bytes at 100 Mbit/s
        fast_eth = 1'b1;
        push_frame(p9, 32'h0, 1'b1, 3);
        source(p9, 3, 1'b0, -1);
        drain("underrun");

        // Single byte 0x00 at 100 Mbit/s
        fast_eth = 1'b1;
        push_frame(p0, 32'hD202_EF8D, 1'b1, -1);
        source(p0, -1, 1'b0, -1);
        drain("single_00");

        // Back-to-back: fast frame, fast_eth dropped mid-frame, next frame at 10 Mbit/s
        fast_eth = 1'b1;
        push_frame(p9, 32'hCBF4_3926, 1'b1, -1);
        exp_q.push_back(6'd0);
        push_frame(p0, 32'hD202_EF8D, 1'b0, -1);
        source(p9, -1, 1'b1, 3);
        source(p0, -1, 1'b0, -1);
        drain("back_to_back");

        // Reset mid-DATA at 10 Mbit/s, then a clean frame
        fast_eth = 1'b0;
        push_frame(p9, 32'hCBF4_3926, 1'b0, -1);
        source(p9, 2, 1'b1, -1);
        repeat (15) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_quiet("async_reset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        #1;
        check_quiet("held_reset");
        rst = 1'b1;
        push_frame(p9, 32'hCBF4_3926, 1'b0, -1);
        source(p9, -1, 1'b0, -1);
        drain("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
